// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// retry, qualifies lock over a stable window and only then releases the core
// reset. Loss of lock or a soft request restarts the whole sequence.
// Clocked from the free-running reference, never from a PLL output.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'b00,
    ST_WAIT   = 2'b01,
    ST_STABLE = 2'b10,
    ST_RUN    = 2'b11
  } state_t;

  // Terminal counts for each timed state
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              cnt_clr_s;
  logic              retry_inc_s;
  logic              lost_set_s;
  logic              sync1_r;
  logic              lk_r;
  logic [7:0]        retry_cnt_r;
  logic              lock_lost_r;
  logic              pll_rst_r;
  logic              core_rst_n_r;
  logic              ready_r;

  // Two-flop synchronizer bringing the asynchronous lock into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      lk_r    <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      lk_r    <= sync1_r;
    end
  end

  // Next-state decode; soft_req overrides every other transition
  always_comb begin
    next_state_s = state_r;
    retry_inc_s  = 1'b0;
    lost_set_s   = 1'b0;
    if (soft_req) begin
      next_state_s = ST_ASSERT;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          if (cnt_r == RST_LAST) begin
            next_state_s = ST_WAIT;
          end else begin
            next_state_s = ST_ASSERT;
          end
        end
        ST_WAIT: begin
          if (lk_r) begin
            next_state_s = ST_STABLE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            next_state_s = ST_ASSERT;
            retry_inc_s  = 1'b1;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        ST_STABLE: begin
          if (!lk_r) begin
            next_state_s = ST_WAIT;
          end else if (cnt_r == STABLE_LAST) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lk_r) begin
            next_state_s = ST_ASSERT;
            lost_set_s   = 1'b1;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        default: begin
          next_state_s = ST_ASSERT;
        end
      endcase
    end
  end

  // The shared counter restarts on any transition and on a soft request
  // (which may re-enter ASSERT from ASSERT without a state change)
  always_comb begin
    cnt_clr_s = 1'b0;
    if (soft_req || (next_state_s != state_r)) begin
      cnt_clr_s = 1'b1;
    end else begin
      cnt_clr_s = 1'b0;
    end
  end

  // State register and shared cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_ASSERT;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Status: saturating timeout-retry count and sticky lock-lost flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt_r <= 8'd0;
      lock_lost_r <= 1'b0;
    end else begin
      if (retry_inc_s && (retry_cnt_r != 8'hFF)) begin
        retry_cnt_r <= retry_cnt_r + 8'd1;
      end
      if (lost_set_s) begin
        lock_lost_r <= 1'b1;
      end
    end
  end

  // Registered outputs decoded from the next state so they align with state_r
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_r    <= 1'b1;
      core_rst_n_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      pll_rst_r    <= (next_state_s == ST_ASSERT);
      core_rst_n_r <= (next_state_s == ST_RUN);
      ready_r      <= (next_state_s == ST_RUN);
    end
  end

  assign pll_rst    = pll_rst_r;
  assign core_rst_n = core_rst_n_r;
  assign ready      = ready_r;
  assign retry_cnt  = retry_cnt_r;
  assign lock_lost  = lock_lost_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. Inputs change and outputs are sampled 1 ns after posedge.
// Edge numbering in comments: E0 is the edge just before a stimulus change.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
  logic       lock_lost;

  int checks;
  int failures;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .soft_req  (soft_req),
    .pll_rst   (pll_rst),
    .core_rst_n(core_rst_n),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; soft_req = 1'b0;
    step(); step();
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL rst_core_rst_n got=%b exp=0", core_rst_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL rst_lock_lost got=%b exp=0", lock_lost); end
  endtask

  // Release reset, 4-cycle pll_rst, lock 10 cycles later, release 11 edges
  // after the lock input rises (2 sync + 1 WAIT->STABLE + 8 stable)
  task automatic test_power_up();
    reset_n = 1'b1;
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL pu_pll_rst0 got=%b exp=1", pll_rst); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL pu_pll_rst_hi%0d got=%b exp=1", i, pll_rst); end
    end
    step();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL pu_pll_rst_lo got=%b exp=0", pll_rst); end
    repeat (6) step();
    pll_locked = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL pu_core_early%0d got=%b exp=0", i, core_rst_n); end
    end
    step();
    checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL pu_core_rel got=%b exp=1", core_rst_n); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL pu_ready got=%b exp=1", ready); end
    checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL pu_retry got=%0d exp=0", retry_cnt); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL pu_lock_lost got=%b exp=0", lock_lost); end
  endtask

  // Drop lock in RUN: leave RUN at E3, 4-cycle pll_rst, relock, lock_lost sticks
  task automatic test_lock_loss();
    pll_locked = 1'b0;
    step(); step();
    checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL ll_core_still_run got=%b exp=1", core_rst_n); end
    step();
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL ll_core got=%b exp=0", core_rst_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ll_ready got=%b exp=0", ready); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL ll_lock_lost got=%b exp=1", lock_lost); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL ll_pll_rst0 got=%b exp=1", pll_rst); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL ll_pll_rst_hi%0d got=%b exp=1", i, pll_rst); end
    end
    step();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL ll_pll_rst_lo got=%b exp=0", pll_rst); end
    pll_locked = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL ll_core_early%0d got=%b exp=0", i, core_rst_n); end
    end
    step();
    checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL ll_core_rel got=%b exp=1", core_rst_n); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL ll_lock_sticky got=%b exp=1", lock_lost); end
    checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL ll_retry got=%0d exp=0", retry_cnt); end
  endtask

  // soft_req in RUN, then again in WAIT while lk=1 (must beat WAIT->STABLE)
  task automatic test_soft_req();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL sr_run_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL sr_run_core got=%b exp=0", core_rst_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL sr_run_ready got=%b exp=0", ready); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL sr_run_hi%0d got=%b exp=1", i, pll_rst); end
    end
    step();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL sr_run_lo got=%b exp=0", pll_rst); end
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL sr_wait_pll_rst got=%b exp=1", pll_rst); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL sr_wait_hi%0d got=%b exp=1", i, pll_rst); end
    end
    step();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL sr_wait_lo got=%b exp=0", pll_rst); end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL sr_core_early%0d got=%b exp=0", i, core_rst_n); end
    end
    step();
    checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL sr_core_rel got=%b exp=1", core_rst_n); end
    checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL sr_retry got=%0d exp=0", retry_cnt); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL sr_lock_lost got=%b exp=1", lock_lost); end
  endtask

  // Lock bounces low 3 cycles inside STABLE: back to WAIT, no retry, full
  // stable window restarts after the final rise
  task automatic test_bounce();
    soft_req = 1'b1; pll_locked = 1'b0;
    step();                       // E1 ASSERT
    soft_req = 1'b0;
    repeat (4) step();            // E5 WAIT
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL bn_pll_rst got=%b exp=0", pll_rst); end
    pll_locked = 1'b1;
    repeat (5) step();            // E10 STABLE, counter 2
    pll_locked = 1'b0;
    repeat (3) step();            // E13 back in WAIT
    pll_locked = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL bn_core_early%0d got=%b exp=0", i, core_rst_n); end
    end
    step();
    checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL bn_core_rel got=%b exp=1", core_rst_n); end
    checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL bn_retry got=%0d exp=0", retry_cnt); end
  endtask

  // No lock: leave RUN at E3, then 24-cycle retry period; count saturates at 255
  task automatic test_no_lock();
    int exp_retry;
    logic exp_rst;
    pll_locked = 1'b0;
    for (int s = 1; s <= 3 + 24 * 257; s++) begin
      step();
      if (s >= 3) begin
        exp_retry = (s - 3) / 24;
        if (exp_retry > 255) exp_retry = 255;
        exp_rst = (((s - 3) % 24) < 4);
        checks++; if (pll_rst !== exp_rst) begin failures++; $display("FAIL nl_pll_rst s=%0d got=%b exp=%b", s, pll_rst, exp_rst); end
        checks++; if (retry_cnt !== 8'(exp_retry)) begin failures++; $display("FAIL nl_retry s=%0d got=%0d exp=%0d", s, retry_cnt, exp_retry); end
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL nl_core s=%0d got=%b exp=0", s, core_rst_n); end
      end
    end
    checks++; if (retry_cnt !== 8'd255) begin failures++; $display("FAIL nl_retry_sat got=%0d exp=255", retry_cnt); end
  endtask

  // reset_n asserted between edges while in STABLE: outputs reset immediately
  task automatic test_async_reset();
    soft_req = 1'b1; pll_locked = 1'b1;
    step();                       // E1 ASSERT
    soft_req = 1'b0;
    repeat (4) step();            // E5 WAIT, lk high
    repeat (3) step();            // E8 STABLE, counter 2
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL ar_pre_pll_rst got=%b exp=0", pll_rst); end
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL ar_pre_core got=%b exp=0", core_rst_n); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL ar_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL ar_core got=%b exp=0", core_rst_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ar_ready got=%b exp=0", ready); end
    checks++; if (retry_cnt !== 8'd0) begin failures++; $display("FAIL ar_retry got=%0d exp=0", retry_cnt); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL ar_lock_lost got=%b exp=0", lock_lost); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_soft_req();
    test_bounce();
    test_no_lock();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
